xor_stream_decoder: RTL and testbench

//  Decodes 32-bit words that were XOR-encoded against a 32-bit LFSR keystream.

---
 rtl/xor_stream_decoder_if.sv | 36 +++
 rtl/xor_stream_decoder.sv | 114 +++++++++++
 tb/tb_xor_stream_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/xor_stream_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : xor_stream_decoder_if
// Description : Valid/ready stream bundle for the XOR keystream decoder.
//               Carries the encoded input word and the decoded output word.
// Revision    : 1.0 - initial release
// ============================================================================
interface xor_stream_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Decoder side: consumes encoded words, produces decoded words
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    // Environment side: supplies encoded words, takes decoded words
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface
`default_nettype wire

// File: rtl/xor_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : xor_stream_decoder
// Description : Decodes 32-bit words XOR-encoded against a 32-bit LFSR
//               keystream regenerated from a shared seed. One registered
//               output stage, one word in flight, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_stream_decoder #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] AUTO_SEED = 32'h0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              seed_load_i,
    input  wire logic [31:0]       seed_i,
    xor_stream_decoder_if.slave    s_if,
    output      logic [CNT_W-1:0]  word_cnt_o,
    output      logic              seed_err_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // A non-zero AUTO_SEED lets the block come out of reset already decoding
    localparam logic [0:0] RST_STATE = (AUTO_SEED != 32'h0) ? ST_RUN : ST_IDLE;

    logic [0:0]       state_q,     state_d;
    logic [31:0]      lfsr_q,      lfsr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q,  out_data_d;
    logic             seed_err_q,  seed_err_d;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_seed_ok;
    logic             w_fb;

    // A zero seed would lock the LFSR at zero, so it is rejected
    assign w_seed_ok = seed_load_i && (seed_i != 32'h0);
    assign w_accept  = s_if.in_valid && w_in_ready;
    assign w_fb      = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any valid seed puts the block in RUN; only reset returns to IDLE
    always_comb begin
        state_d = state_q;
        if (w_seed_ok) begin
            state_d = ST_RUN;
        end
    end

    // Input ready: a seed load takes priority over accepting a word
    always_comb begin
        w_in_ready = (state_q == ST_RUN) && !seed_load_i &&
                     (!out_valid_q || s_if.out_ready);
    end

    // Datapath next values: keystream, counter, output stage, seed error pulse
    always_comb begin
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        seed_err_d  = seed_load_i && (seed_i == 32'h0);
        if (w_seed_ok) begin
            lfsr_d = seed_i;
            cnt_d  = '0;
        end
        if (w_accept) begin
            // Key is the LFSR value before this word's advance
            out_data_d  = s_if.in_data ^ lfsr_q;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
            lfsr_d      = {lfsr_q[30:0], w_fb};
        end else if (s_if.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= AUTO_SEED;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            seed_err_q  <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = out_valid_q;
    assign s_if.out_data  = out_data_q;
    assign word_cnt_o     = cnt_q;
    assign seed_err_o     = seed_err_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_stream_decoder
// Description : Self-checking bench for xor_stream_decoder: directed cases
//               with literal expectations plus randomized traffic compared
//               every cycle against a keystream-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_stream_decoder;

    localparam int          TB_CNT_W = 4;
    localparam logic [31:0] TB_AUTO  = 32'h0000_ACE1;

    logic clk = 1'b0;
    logic rst_n;
    logic seed_load;
    logic [31:0] seed;
    logic [TB_CNT_W-1:0] word_cnt;
    logic seed_err;

    logic [15:0] word_cnt2;
    logic seed_err2;

    int n_total = 0;
    int n_pass  = 0;

    xor_stream_decoder_if if1 ();
    xor_stream_decoder_if if2 ();

    xor_stream_decoder #(.CNT_W(TB_CNT_W), .AUTO_SEED(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_load_i(seed_load),
        .seed_i     (seed),
        .s_if       (if1.slave),
        .word_cnt_o (word_cnt),
        .seed_err_o (seed_err)
    );

    xor_stream_decoder #(.CNT_W(16), .AUTO_SEED(TB_AUTO)) dut_auto (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_load_i(1'b0),
        .seed_i     (32'h0),
        .s_if       (if2.slave),
        .word_cnt_o (word_cnt2),
        .seed_err_o (seed_err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Key for word number n after seeding with s: s stepped n times
    function automatic logic [31:0] ks(input logic [31:0] s, input int n);
        logic [31:0] x;
        x = s;
        for (int k = 0; k < n; k++) x = {x[30:0], ^(x & 32'h8020_0003)};
        return x;
    endfunction

    // ---------------- reference model ----------------
    bit          m_run;
    logic [31:0] m_seed;
    int          m_n;      // words accepted since last seed/reset
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_err;
    logic        exp_rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_run = 1'b0; m_seed = 32'h0; m_n = 0;
            m_valid = 1'b0; m_data = 32'h0; m_err = 1'b0;
        end
        exp_rdy = m_run && !seed_load && (!m_valid || if1.out_ready);
        chk("in_ready",  {31'h0, if1.in_ready},  {31'h0, exp_rdy});
        chk("out_valid", {31'h0, if1.out_valid}, {31'h0, m_valid});
        if (m_valid) chk("out_data", if1.out_data, m_data);
        chk("word_cnt",  {28'h0, word_cnt}, 32'(m_n % (2 ** TB_CNT_W)));
        chk("seed_err",  {31'h0, seed_err},  {31'h0, m_err});
        if (rst_n) begin
            m_err = seed_load && (seed == 32'h0);
            if (seed_load && seed != 32'h0) begin
                m_run = 1'b1; m_seed = seed; m_n = 0;
            end
            if (exp_rdy && if1.in_valid) begin
                m_data  = if1.in_data ^ ks(m_seed, m_n);
                m_valid = 1'b1;
                m_n++;
            end else if (if1.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] orig [0:16];
    logic [31:0] s6;

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed = 32'h0;
        if1.in_valid = 1'b1; if1.in_data = 32'h0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b1; if2.in_data = 32'h0; if2.out_ready = 1'b1;
        cyc(); cyc();

        // 1: reset state, unseeded block refuses words; auto-seeded block runs
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_in_ready",  {31'h0, if1.in_ready},  32'h0);
        chk("t1_out_valid", {31'h0, if1.out_valid}, 32'h0);
        chk("t1_out_data",  if1.out_data, 32'h0);
        chk("t1_word_cnt",  {28'h0, word_cnt}, 32'h0);
        chk("auto_in_ready", {31'h0, if2.in_ready}, 32'h1);
        cyc(); if2.in_valid = 1'b0;
        @(negedge clk);
        chk("auto_out_valid", {31'h0, if2.out_valid}, 32'h1);
        chk("auto_out_data",  if2.out_data, 32'h0000_ACE1);
        chk("auto_word_cnt",  {16'h0, word_cnt2}, 32'h1);
        chk("auto_seed_err",  {31'h0, seed_err2}, 32'h0);

        // 2: seed 1, three zero words back to back
        cyc(); seed_load = 1'b1; seed = 32'h1; if1.in_valid = 1'b0;
        cyc(); seed_load = 1'b0; if1.in_valid = 1'b1; if1.in_data = 32'h0;
        cyc();
        @(negedge clk); chk("t2_w0", if1.out_data, 32'h1);
        chk("t2_v0", {31'h0, if1.out_valid}, 32'h1);
        cyc();
        @(negedge clk); chk("t2_w1", if1.out_data, 32'h3);
        cyc(); if1.in_valid = 1'b0;
        @(negedge clk); chk("t2_w2", if1.out_data, 32'h6);
        chk("t2_cnt", {28'h0, word_cnt}, 32'h3);

        // 3: back-pressure holds the word and blocks input
        cyc(); seed_load = 1'b1; seed = 32'h1;
        cyc(); seed_load = 1'b0; if1.in_valid = 1'b1; if1.in_data = 32'hFFFF_FFFF;
        if1.out_ready = 1'b0;
        cyc(); if1.in_data = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_data", if1.out_data, 32'hFFFF_FFFE);
            chk("t3_hold_rdy",  {31'h0, if1.in_ready}, 32'h0);
            cyc();
        end
        if1.out_ready = 1'b1;
        cyc(); if1.in_valid = 1'b0;
        @(negedge clk); chk("t3_next_key3", if1.out_data, 32'h1234_567B);

        // 4: zero seed rejected in RUN, keystream continues from 6
        cyc(); seed_load = 1'b1; seed = 32'h0;
        cyc(); seed_load = 1'b0;
        @(negedge clk); chk("t4_err_pulse", {31'h0, seed_err}, 32'h1);
        cyc(); if1.in_valid = 1'b1; if1.in_data = 32'h0;
        @(negedge clk); chk("t4_err_clear", {31'h0, seed_err}, 32'h0);
        cyc(); if1.in_valid = 1'b0;
        @(negedge clk); chk("t4_old_key", if1.out_data, 32'h6);

        // 5: seed_load beats a simultaneous word
        cyc(); seed_load = 1'b1; seed = 32'hDEAD_BEEF;
        if1.in_valid = 1'b1; if1.in_data = 32'h0F0F_0F0F;
        @(negedge clk); chk("t5_rdy_blocked", {31'h0, if1.in_ready}, 32'h0);
        cyc(); seed_load = 1'b0;
        @(negedge clk); chk("t5_cnt0", {28'h0, word_cnt}, 32'h0);
        chk("t5_not_taken", {31'h0, if1.out_valid}, 32'h0);
        cyc(); if1.in_valid = 1'b0;
        @(negedge clk); chk("t5_new_key", if1.out_data, 32'hD1A2_B1E0);
        chk("t5_cnt1", {28'h0, word_cnt}, 32'h1);

        // 6: counter wrap with round-trip through an encoder model
        s6 = 32'hC0FF_EE11;
        for (int i = 0; i < 17; i++) orig[i] = $urandom;
        cyc(); seed_load = 1'b1; seed = s6; if1.in_valid = 1'b0;
        cyc(); seed_load = 1'b0; if1.in_valid = 1'b1; if1.in_data = orig[0] ^ ks(s6, 0);
        for (int i = 1; i <= 17; i++) begin
            cyc();
            if (i < 17) if1.in_data = orig[i] ^ ks(s6, i);
            else        if1.in_valid = 1'b0;
            @(negedge clk);
            chk("t6_roundtrip", if1.out_data, orig[i-1]);
            if (i == 15) chk("t6_cnt15", {28'h0, word_cnt}, 32'hF);
            if (i == 16) chk("t6_cnt_wrap0", {28'h0, word_cnt}, 32'h0);
            if (i == 17) chk("t6_cnt_wrap1", {28'h0, word_cnt}, 32'h1);
        end

        // Randomized traffic with occasional reseeds, zero seeds and a mid-stream reset
        for (int c = 0; c < 1500; c++) begin
            cyc();
            if (c == 700)      rst_n = 1'b0;
            else if (c == 702) rst_n = 1'b1;
            if1.in_valid  = ($urandom_range(99) < 70);
            if1.in_data   = $urandom;
            if1.out_ready = ($urandom_range(99) < 70);
            seed_load     = ($urandom_range(99) < 5);
            seed          = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
        end
        cyc();
        seed_load = 1'b0; if1.in_valid = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
